tribus_arbiter: RTL and testbench

Sequential arbiter granting ownership of a shared multi-driver `tri` net to one of `N_REQ` requesters at a time.
- Enforces round-robin fairness, a bounded hold time and a mandatory high-Z turnaround between owners.
- Guarantees that at most one driver enable is active in any cycle.
- Sits between the requester blocks and the per-requester tri-state drivers (`bufif1`-style) on the shared net.

---
 rtl/tribus_pkg.sv | 15 +
 rtl/tribus_rr_pick.sv | 34 +++
 rtl/tribus_arbiter.sv | 136 +++++++++++++
 tb/tb_tribus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tribus_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
package tribus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } tribus_state_e;

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tribus_rr_pick.sv
// Round-robin pick: first set request at or after the pointer, wrapping modulo N_REQ.
module tribus_rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic                     o_valid,
    output logic [$clog2(N_REQ)-1:0] o_idx
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam logic [IW:0] NR = (IW + 1)'(N_REQ);

    logic [N_REQ-1:0] w_rot;
    logic [IW-1:0]    w_off;
    logic [IW:0]      w_sum;
    logic [IW:0]      w_wrap;

    always_comb begin
        // Rotating the doubled vector puts bit ptr at position 0.
        w_rot = N_REQ'({i_req, i_req} >> i_ptr);
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IW'(i);
            end
        end
        o_valid = |i_req;
        w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
        w_wrap  = w_sum - NR;
        o_idx   = (w_sum >= NR) ? w_wrap[IW-1:0] : w_sum[IW-1:0];
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Arbiter for a shared tri-state net: round-robin owner selection, bounded hold,
// and a high-Z turnaround so two drivers are never enabled in adjacent cycles.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     timeout
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned HW = cnt_width(MAX_HOLD);
    localparam int unsigned TW = cnt_width(TURN_CYC);

    localparam logic [HW-1:0]    HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [TW-1:0]    TURN_INIT = TW'(TURN_CYC);
    localparam logic [IW-1:0]    LAST_IDX  = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    tribus_state_e    r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IW-1:0]    r_owner;
    logic             r_busy;
    logic             r_timeout;
    logic [IW-1:0]    r_ptr;
    logic [HW-1:0]    r_hold;
    logic [TW-1:0]    r_turn;

    tribus_state_e    w_state_d;
    logic [N_REQ-1:0] w_gnt_d;
    logic [IW-1:0]    w_owner_d;
    logic             w_busy_d;
    logic             w_timeout_d;
    logic [IW-1:0]    w_ptr_d;
    logic [HW-1:0]    w_hold_d;
    logic [TW-1:0]    w_turn_d;

    logic             w_valid;
    logic [IW-1:0]    w_idx;
    logic             w_release;

    tribus_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_turn    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_gnt     <= w_gnt_d;
            r_owner   <= w_owner_d;
            r_busy    <= w_busy_d;
            r_timeout <= w_timeout_d;
            r_ptr     <= w_ptr_d;
            r_hold    <= w_hold_d;
            r_turn    <= w_turn_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_gnt_d     = r_gnt;
        w_owner_d   = r_owner;
        w_timeout_d = 1'b0;
        w_ptr_d     = r_ptr;
        w_hold_d    = r_hold;
        w_turn_d    = r_turn;
        w_release   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_d = OWN;
                    w_gnt_d   = ONE_HOT0 << w_idx;
                    w_owner_d = w_idx;
                    w_hold_d  = HW'(1);
                end
            end
            OWN: begin
                // Other requesters cannot preempt; only the owner's own request matters.
                w_release = !req[r_owner] || (r_hold == HOLD_MAX);
                if (w_release) begin
                    w_timeout_d = req[r_owner];
                    w_gnt_d     = '0;
                    w_owner_d   = '0;
                    w_ptr_d     = (r_owner == LAST_IDX) ? '0 : r_owner + IW'(1);
                    w_turn_d    = TURN_INIT;
                    w_state_d   = (TURN_CYC == 0) ? IDLE : TURN;
                end else begin
                    w_hold_d = r_hold + HW'(1);
                end
            end
            TURN: begin
                w_gnt_d  = '0;
                w_turn_d = r_turn - TW'(1);
                if (r_turn <= TW'(1)) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_gnt_d   = '0;
                w_owner_d = '0;
            end
        endcase

        w_busy_d = (w_state_d != IDLE);
    end

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: three instances (TURN_CYC = 1, 0, 2) checked every cycle against
// an abstract arbitration model, plus directed scenarios with literal expectations on instance 0.
module tb_tribus_arbiter;

    logic       clk;
    logic       rst_a   [3];
    logic [3:0] req_a   [3];
    logic [3:0] gnt_a   [3];
    logic [1:0] owner_a [3];
    logic       busy_a  [3];
    logic       to_a    [3];
    bit         chk_en;
    int         n_checks;
    int         n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input int cfg, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: actual 0x%0h required 0x%0h", cfg, name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned TC = (g == 0) ? 1 : ((g == 1) ? 0 : 2);

        // Model: current owner (-1 = none), cycles held, idle cycles still owed, pointer.
        int         m_own  = -1;
        int         m_held = 0;
        int         m_gap  = 0;
        int         m_ptr  = 0;
        bit         m_to   = 1'b0;
        logic [3:0] prev_gnt;

        tribus_arbiter #(
            .N_REQ    (4),
            .MAX_HOLD (4),
            .TURN_CYC (TC)
        ) u_dut (
            .clk     (clk),
            .rst     (rst_a[g]),
            .req     (req_a[g]),
            .gnt     (gnt_a[g]),
            .owner   (owner_a[g]),
            .busy    (busy_a[g]),
            .timeout (to_a[g])
        );

        always @(posedge clk) begin : p_model
            int own, held, gap, ptr;
            bit to;
            own  = m_own;
            held = m_held;
            gap  = m_gap;
            ptr  = m_ptr;
            to   = 1'b0;
            if (rst_a[g]) begin
                own  = -1;
                held = 0;
                gap  = 0;
                ptr  = 0;
            end else if (own >= 0) begin
                if (!req_a[g][own] || held == 4) begin
                    to   = req_a[g][own];
                    ptr  = (own + 1) % 4;
                    own  = -1;
                    gap  = TC;
                end else begin
                    held++;
                end
            end else if (gap > 0) begin
                gap--;
            end else if (req_a[g] != 4'b0) begin
                for (int j = 0; j < 4; j++) begin
                    if (own < 0 && req_a[g][(ptr + j) % 4]) own = (ptr + j) % 4;
                end
                held = 1;
            end
            m_own  <= own;
            m_held <= held;
            m_gap  <= gap;
            m_ptr  <= ptr;
            m_to   <= to;
        end

        always @(negedge clk) begin : p_cmp
            logic [31:0] exp_gnt;
            bit          b2b_ok;
            bit          own_ok;
            if (chk_en) begin
                exp_gnt = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
                check(g, "gnt", {28'd0, gnt_a[g]}, exp_gnt);
                check(g, "owner", {30'd0, owner_a[g]}, (m_own >= 0) ? m_own : 0);
                check(g, "busy", {31'd0, busy_a[g]}, {31'd0, (m_own >= 0 || m_gap > 0)});
                check(g, "timeout", {31'd0, to_a[g]}, {31'd0, m_to});
                check(g, "onehot0", {31'd0, ($countones(gnt_a[g]) <= 1)}, 32'd1);
                b2b_ok = !(prev_gnt != 4'b0 && gnt_a[g] != 4'b0 && prev_gnt != gnt_a[g]);
                check(g, "no_b2b", {31'd0, b2b_ok}, 32'd1);
                own_ok = (gnt_a[g] == 4'b0) ? (owner_a[g] == 2'd0)
                                            : (gnt_a[g] == (4'b0001 << owner_a[g]));
                check(g, "owner_vs_gnt", {31'd0, own_ok}, 32'd1);
            end
            prev_gnt <= gnt_a[g];
        end
    end

    initial begin : p_stim
        logic [3:0] rr_exp [5];
        int gap;
        int hi;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rst_a[c] = 1'b1;
            req_a[c] = 4'b0;
        end
        tick();
        tick();
        chk_en = 1'b1;
        for (int c = 0; c < 3; c++) rst_a[c] = 1'b0;

        // 1. Reset mid-grant
        req_a[0] = 4'b0010;
        tick();
        check(0, "t1_gnt", {28'd0, gnt_a[0]}, 32'h2);
        check(0, "t1_busy", {31'd0, busy_a[0]}, 32'h1);
        rst_a[0] = 1'b1;
        tick();
        check(0, "t1_rst_gnt", {28'd0, gnt_a[0]}, 32'h0);
        check(0, "t1_rst_owner", {30'd0, owner_a[0]}, 32'h0);
        check(0, "t1_rst_busy", {31'd0, busy_a[0]}, 32'h0);
        check(0, "t1_rst_timeout", {31'd0, to_a[0]}, 32'h0);
        rst_a[0] = 1'b0;
        tick();
        check(0, "t1_regnt", {28'd0, gnt_a[0]}, 32'h2);
        check(0, "t1_reowner", {30'd0, owner_a[0]}, 32'h1);
        req_a[0] = 4'b0;
        tick();
        tick();

        // 2. Round-robin, each owner releasing after two cycles
        rst_a[0] = 1'b1;
        tick();
        rst_a[0] = 1'b0;
        req_a[0] = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            check(0, "t2_order", {28'd0, gnt_a[0]}, {28'd0, rr_exp[i]});
            tick();
            req_a[0] = 4'b1111 & ~rr_exp[i];
            tick();
            req_a[0] = 4'b1111;
            gap = 0;
            while (gnt_a[0] == 4'b0 && gap < 10) begin
                gap++;
                tick();
            end
            check(0, "t2_gap", gap, 32'd2);
        end
        req_a[0] = 4'b0;
        tick();
        tick();

        // 3. Timeout under a continuous request
        req_a[0] = 4'b0100;
        tick();
        hi = 1;
        while (gnt_a[0] == 4'b0100 && hi < 20) begin
            tick();
            if (gnt_a[0] == 4'b0100) hi++;
        end
        check(0, "t3_hold_len", hi, 32'd4);
        check(0, "t3_timeout", {31'd0, to_a[0]}, 32'h1);
        check(0, "t3_drop_gnt", {28'd0, gnt_a[0]}, 32'h0);
        tick();
        check(0, "t3_timeout_pulse", {31'd0, to_a[0]}, 32'h0);
        tick();
        check(0, "t3_regnt", {28'd0, gnt_a[0]}, 32'h4);
        check(0, "t3_reowner", {30'd0, owner_a[0]}, 32'h2);
        req_a[0] = 4'b0;
        tick();
        tick();

        // 4. No preemption
        req_a[0] = 4'b1000;
        tick();
        check(0, "t4_gnt", {28'd0, gnt_a[0]}, 32'h8);
        req_a[0] = 4'b1001;
        repeat (2) begin
            tick();
            check(0, "t4_hold", {28'd0, gnt_a[0]}, 32'h8);
        end
        req_a[0] = 4'b0001;
        tick();
        check(0, "t4_gap1", {28'd0, gnt_a[0]}, 32'h0);
        tick();
        check(0, "t4_gap2", {28'd0, gnt_a[0]}, 32'h0);
        tick();
        check(0, "t4_next", {28'd0, gnt_a[0]}, 32'h1);
        req_a[0] = 4'b0;
        tick();
        tick();

        // 5. Pointer wrap: owner 3 times out with 1001 pending
        req_a[0] = 4'b1000;
        tick();
        check(0, "t5_gnt3", {28'd0, gnt_a[0]}, 32'h8);
        req_a[0] = 4'b1001;
        repeat (4) tick();
        check(0, "t5_drop", {28'd0, gnt_a[0]}, 32'h0);
        check(0, "t5_timeout", {31'd0, to_a[0]}, 32'h1);
        tick();
        tick();
        check(0, "t5_wrap_gnt", {28'd0, gnt_a[0]}, 32'h1);
        check(0, "t5_wrap_owner", {30'd0, owner_a[0]}, 32'h0);
        req_a[0] = 4'b0;
        repeat (3) tick();

        // 6. Random requests on all three turnaround settings
        for (int c = 0; c < 10000; c++) begin
            for (int ci = 0; ci < 3; ci++) begin
                rst_a[ci] = ($urandom_range(0, 499) == 0);
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 5) == 0) req_a[ci][b] = ~req_a[ci][b];
                end
            end
            tick();
        end
        for (int ci = 0; ci < 3; ci++) begin
            rst_a[ci] = 1'b0;
            req_a[ci] = 4'b0;
        end
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
